// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, colour width helper, RGB332 payload.
package vga_pkg;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 11;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 28;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   function automatic int unsigned col_w(input int unsigned rw, input int unsigned gw,
                                         input int unsigned bw);
      return rw + gw + bw;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter laid out as sync, back porch, active, front porch.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned SYNC   = 96,
   parameter int unsigned BP     = 48,
   parameter int unsigned ACTIVE = 640,
   parameter int unsigned FP     = 16,
   parameter int unsigned CNT_W  = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             adv,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap_c,
   output logic             in_sync_c,
   output logic             in_active_c,
   output logic [CNT_W-1:0] offset_c
);

   localparam int unsigned TOTAL  = SYNC + BP + ACTIVE + FP;
   localparam int unsigned ACT_LO = SYNC + BP;
   localparam int unsigned ACT_HI = ACT_LO + ACTIVE;

   // One extra bit so the active window's upper bound cannot overflow the counter width.
   localparam logic [CNT_W:0]   SYNC_L = (CNT_W+1)'(SYNC);
   localparam logic [CNT_W:0]   LO_L   = (CNT_W+1)'(ACT_LO);
   localparam logic [CNT_W:0]   HI_L   = (CNT_W+1)'(ACT_HI);
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] OFF    = CNT_W'(ACT_LO);

   assign wrap_c      = adv && (cnt == LAST);
   assign in_sync_c   = {1'b0, cnt} < SYNC_L;
   assign in_active_c = ({1'b0, cnt} >= LO_L) && ({1'b0, cnt} < HI_L);
   assign offset_c    = cnt - OFF;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en) begin
         cnt <= '0;
      end else if (adv) begin
         cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: issues (x,y) one pixel tick ahead, registers colour to the pins.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CLK_DIV  = 1,
   parameter int unsigned CNT_W    = 10,
   parameter int unsigned R_W      = 3,
   parameter int unsigned G_W      = 3,
   parameter int unsigned B_W      = 2,
   localparam int unsigned COL_W   = col_w(R_W, G_W, B_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [COL_W-1:0] color,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             req,
   output logic [R_W-1:0]   r,
   output logic [G_W-1:0]   g,
   output logic [B_W-1:0]   b,
   output logic             hs,
   output logic             vs,
   output logic             disp,
   output logic             pix_tick,
   output logic             frame_start,
   output logic             line_start
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if ((((H_TOTAL - 1) >> CNT_W) != 0) || (((V_TOTAL - 1) >> CNT_W) != 0)) begin : g_bad_cnt_w
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
   end
   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV must be >= 1");
   end

   logic [DIV_W-1:0] div;
   logic             tick;
   logic [CNT_W-1:0] h_cnt, v_cnt, h_off, v_off;
   logic             h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
   logic             hs1, vs1, act1;
   logic             unused_cnt;

   // Gated by rst so the strobe reads low while reset is held, even with en high.
   assign tick        = en && !rst && (div == DIV_LAST);
   assign pix_tick    = tick;
   assign line_start  = h_wrap;
   assign frame_start = h_wrap && v_wrap;
   assign req         = act1;
   assign unused_cnt  = ^{h_cnt, v_cnt};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
      end else if (!en || (div == DIV_LAST)) begin
         div <= '0;
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   vga_axis_counter #(
      .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CNT_W(CNT_W)
   ) u_h (
      .clk(clk), .rst(rst), .en(en), .adv(tick),
      .cnt(h_cnt), .wrap_c(h_wrap), .in_sync_c(h_sync), .in_active_c(h_act), .offset_c(h_off)
   );

   vga_axis_counter #(
      .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CNT_W(CNT_W)
   ) u_v (
      .clk(clk), .rst(rst), .en(en), .adv(h_wrap),
      .cnt(v_cnt), .wrap_c(v_wrap), .in_sync_c(v_sync), .in_active_c(v_act), .offset_c(v_off)
   );

   // Stage 1: request coordinates and remember sync/active for the pin stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs1 <= 1'b0; vs1 <= 1'b0; act1 <= 1'b0; x <= '0; y <= '0;
      end else if (!en) begin
         hs1 <= 1'b0; vs1 <= 1'b0; act1 <= 1'b0; x <= '0; y <= '0;
      end else if (tick) begin
         hs1  <= h_sync;
         vs1  <= v_sync;
         act1 <= h_act && v_act;
         x    <= h_off;
         y    <= v_off;
      end
   end

   // Stage 2: pins, with colour blanked outside the active window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp <= 1'b0; {r, g, b} <= '0; hs <= ~HS_POL; vs <= ~VS_POL;
      end else if (!en) begin
         disp <= 1'b0; {r, g, b} <= '0; hs <= ~HS_POL; vs <= ~VS_POL;
      end else if (tick) begin
         disp      <= act1;
         {r, g, b} <= act1 ? color : COL_W'(0);
         hs        <= hs1 ? HS_POL : ~HS_POL;
         vs        <= vs1 ? VS_POL : ~VS_POL;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on an 8x6 raster, CLK_DIV=3, active-high hs.
module tb_vga_timing_gen;

   logic       clk = 1'b0;
   logic       rst, en;
   logic [7:0] color;
   logic [3:0] x, y;
   logic       req, hs, vs, disp, pix_tick, frame_start, line_start;
   logic [2:0] r, g;
   logic [1:0] b;
   bit         hold;

   always #5 clk = ~clk;

   // Framebuffer stand-in: colour is a fixed function of the requested coordinate.
   assign color = hold ? 8'hFF : ({x, y} ^ 8'hA5);

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(3), .CNT_W(4),
      .R_W(3), .G_W(3), .B_W(2)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .color(color), .x(x), .y(y), .req(req),
      .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .disp(disp), .pix_tick(pix_tick),
      .frame_start(frame_start), .line_start(line_start)
   );

   typedef struct packed {
      logic       req;
      logic [3:0] x;
      logic [3:0] y;
      logic       hs;
      logic       vs;
      logic       disp;
      logic [7:0] rgb;
      logic       ls;
      logic       fs;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   gap      = 0;
   int   disp_cnt = 0;
   int   hs_cnt   = 0;

   // Expected DUT view during the k-th pixel tick after start: strobes from counter state k,
   // request from state k-1, pins from state k-2 (negative state = reset values).
   function automatic exp_t model(int k, bit hold_m);
      exp_t e;
      int   h, v, s;
      bit   a;
      e    = '0;
      e.ls = (k % 8) == 7;
      e.fs = e.ls && (((k / 8) % 6) == 5);
      s = k - 1;
      if (s >= 0) begin
         h = s % 8; v = (s / 8) % 6;
         e.req = (h >= 3) && (h < 7) && (v >= 2) && (v < 5);
         e.x   = 4'(h - 3);
         e.y   = 4'(v - 2);
      end
      s = k - 2;
      if (s < 0) begin
         e.hs = 1'b0; e.vs = 1'b1;
      end else begin
         h = s % 8; v = (s / 8) % 6;
         a = (h >= 3) && (h < 7) && (v >= 2) && (v < 5);
         e.hs   = (h < 2);
         e.vs   = (v >= 1);
         e.disp = a;
         e.rgb  = a ? (hold_m ? 8'hFF : ({4'(h - 3), 4'(v - 2)} ^ 8'hA5)) : 8'h00;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_hs"},   32'(hs), 32'd0);
      chk({tag, "_vs"},   32'(vs), 32'd1);
      chk({tag, "_rgb"},  32'({r, g, b}), 32'd0);
      chk({tag, "_ctl"},  32'({req, disp, pix_tick, line_start, frame_start}), 32'd0);
      chk({tag, "_xy"},   32'({x, y}), 32'd0);
   endtask

   task automatic start_seg(input int n, input bit use_rst);
      q.delete();
      for (int k = 0; k < n; k++) q.push_back(model(k, hold));
      @(posedge clk);
      #2;
      gap = 0;
      if (use_rst) rst = 1'b0;
      else en = 1'b1;
   endtask

   task automatic drain(input int left, input string tag);
      int bud = 0;
      while (q.size() > left && bud < 400) begin
         @(negedge clk);
         bud++;
      end
      if (q.size() > left) begin
         n_checks++; n_fail++;
         $display("FAIL %s_timeout: %0d ticks still pending, expected %0d", tag, q.size(), left);
      end
   endtask

   task automatic stop_en();
      @(posedge clk);
      #2;
      en = 1'b0;
   endtask

   // Monitor: each DUT pixel tick pops one expected view and checks tick spacing.
   always @(negedge clk) begin
      exp_t e, a;
      gap++;
      if (pix_tick) begin
         a = {req, x, y, hs, vs, disp, r, g, b, line_start, frame_start};
         if (q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_tick: got view %h, expected no tick", a);
         end else begin
            e = q.pop_front();
            n_checks++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL tick_view (req,x,y,hs,vs,disp,rgb,ls,fs): got %h, expected %h", a, e);
            end
            n_checks++;
            if (gap != 3) begin
               n_fail++;
               $display("FAIL tick_gap: got %0d clks, expected 3", gap);
            end
         end
         if (disp) disp_cnt++;
         if (hs) hs_cnt++;
         gap = 0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bud;
      rst  = 1'b1;
      en   = 1'b0;
      hold = 1'b0;
      #23;
      chk_idle("reset");
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle("idle_after_reset");

      // Two frames plus a bit with coordinate-derived colour.
      disp_cnt = 0; hs_cnt = 0;
      start_seg(100, 1'b0);
      drain(0, "seg_main");
      chk("disp_pixels", 32'(disp_cnt), 32'd24);
      chk("hs_high_ticks", 32'(hs_cnt), 32'd26);
      stop_en();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_idle("en_low");

      // Saturated colour input must still blank outside active video.
      hold = 1'b1;
      start_seg(48, 1'b0);
      drain(0, "seg_hold");
      stop_en();
      hold = 1'b0;
      repeat (2) @(posedge clk);

      // Drop en mid-frame for 50 clks, then restart from (0,0) with a full frame to frame_start.
      start_seg(60, 1'b0);
      drain(30, "seg_pre_drop");
      stop_en();
      repeat (50) @(posedge clk);
      @(negedge clk);
      chk_idle("en_drop");
      start_seg(50, 1'b0);
      drain(0, "seg_restart");

      // Asynchronous reset while hs is in its pulse, en still high.
      stop_en();
      repeat (2) @(posedge clk);
      start_seg(40, 1'b0);
      bud = 0;
      while (hs !== 1'b1 && bud < 200) begin
         @(negedge clk);
         bud++;
      end
      chk("hs_pulse_seen", 32'(hs), 32'd1);
      #2;
      rst = 1'b1;
      q.delete();
      #1;
      chk_idle("async_rst");
      repeat (3) @(posedge clk);
      start_seg(48, 1'b1);
      drain(0, "seg_after_rst");
      stop_en();
      repeat (4) @(posedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster generator and pixel pipeline; the next generation of the team's fixed 640x480 VGA controller.
- Timing, sync polarity, pixel-clock division and colour width are all parameters.
- Issues pixel coordinates to the framebuffer/renderer one pixel tick ahead, takes back a packed colour, and drives the RGB/sync pins phase-aligned.
- Forces RGB to zero during blanking and provides frame/line strobes plus a run-time enable.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 11, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 28, vertical back porch
HS_POL, 0, hs level during sync pulse (0 = active-low)
VS_POL, 0, vs level during sync pulse
CLK_DIV, 1, system clocks per pixel tick (>=1)
CNT_W, 10, width of h/v counters and x/y (must hold H_TOTAL-1 and V_TOTAL-1)
R_W, 3; G_W, 3; B_W, 2; colour channel widths. COL_W = R_W+G_W+B_W.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  run enable; low holds the raster idle
color  in  COL_W  pixel colour for last requested (x,y), packed {R,G,B}, R in MSBs
x  out  CNT_W  requested pixel column (0..H_ACTIVE-1 when req=1)
y  out  CNT_W  requested pixel row
req  out  1  x/y is a visible pixel; colour expected by next tick
r  out  R_W  red pin
g  out  G_W  green pin
b  out  B_W  blue pin
hs  out  1  horizontal sync pin
vs  out  1  vertical sync pin
disp  out  1  r/g/b currently carries visible data
pix_tick  out  1  one-clk strobe, pipeline advance
frame_start  out  1  one-clk pulse, raster wraps to (0,0)
line_start  out  1  one-clk pulse, h counter wraps to 0

Behaviour:
- Derived constants:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
  - Line order: sync, back porch, active, front porch.
- Divider:
  - div counts 0..CLK_DIV-1 while en=1.
  - pix_tick = en && div==CLK_DIV-1; with CLK_DIV=1, pix_tick = en.
- Counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1 advance only on pix_tick:
  - h wraps to 0 at H_TOTAL-1; v increments on that wrap.
  - v wraps to 0 at V_TOTAL-1 concurrently.
  - line_start/frame_start are asserted in the clk of the wrapping tick.
- Stage 1 (registered on pix_tick, from current counters):
  - hs1 = (h_cnt < H_SYNC); vs1 = (v_cnt < V_SYNC).
  - act1 = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) && v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP), both truncated to CNT_W.
  - req = act1.
- Stage 2 (registered on pix_tick):
  - disp = act1.
  - {r,g,b} = act1 ? color : 0.
  - hs = hs1 ? HS_POL : ~HS_POL; vs likewise.
- Latency:
  - Counter to pins: 2 ticks.
  - color is sampled on the tick after req/x/y are presented, so the source gets exactly one tick (CLK_DIV clks).
- Reset (async, any time):
  - div, h_cnt, v_cnt, x, y = 0.
  - req, disp, r, g, b, pix_tick, frame_start, line_start = 0.
  - hs = ~HS_POL; vs = ~VS_POL.
- en=0:
  - Registers take their reset values at the next clk edge (synchronous idle).
  - en re-rising restarts the raster at (0,0).
  - The first pix_tick after en rises asserts neither frame_start nor line_start; only wraps do.
- Colour is never passed through when act1=0, whatever the color input.
- Parameter sanity: an elaboration-time check errors if CNT_W is too narrow or CLK_DIV<1.

Decomposition:
- Shared package vga_pkg:
  - default 640x480@60 timing constants.
  - COL_W helper function.
  - typedef for packed RGB332.
- One natural sub-module: vga_axis_counter.
  - Parametrised by SYNC, BP, ACTIVE, FP.
  - Counts on an advance input and outputs count, wrap, in_sync, in_active and active offset.
  - Instantiated twice (h advances on pix_tick, v on h wrap).

Test Plan:
1. Defaults, CLK_DIV=1, en=1 after reset:
   - hs low for exactly 96 ticks of every 800.
   - vs low for exactly 1600 ticks (2 lines) of 521*800.
   - frame_start period = 416800 clks.
2. Defaults, color driven as function f(x,y) = x[7:0]^y[7:0]:
   - At pins, disp=1 for exactly 640x480 pixels/frame.
   - {r,g,b} at each visible pixel equals f of the (x,y) issued 1 tick earlier.
   - First visible pin pixel is at h_cnt=146, v_cnt=30 counter time (2-tick latency).
3. Small raster (H: 4/1/2/1, V: 3/1/1/1), CLK_DIV=3, HS_POL=1:
   - pix_tick every 3rd clk.
   - hs high 2 ticks of 8.
   - x sequence 0,1,2,3 with req=1 on 3 lines/frame.
4. color held at 8'hFF throughout:
   - r/g/b = 0 whenever disp=0, including the porch ticks on both sides of active video.
5. rst pulsed asynchronously mid-line (between clk edges):
   - Outputs take reset values immediately (hs/vs inactive, rgb 0).
   - After release, the first hs pulse starts at tick 0.
6. en dropped for 50 clks mid-frame, then raised:
   - Outputs idle during low.
   - Raster restarts at h=v=0.
   - No spurious frame_start on restart; next frame_start after a full 416800 clks.
